// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine
//   UART transmit engine. A word is captured on Data_Valid while idle and sent
//   as one frame: a start bit, DATA_WIDTH data bits LSB-first, an optional
//   even/odd parity bit, then one or two stop bits. Each bit lasts Prescale+1
//   clock cycles. The frame settings are latched at capture, so changing the
//   inputs mid-frame has no effect on the frame already being sent.
//
// Parameters
//   DATA_WIDTH     : data bits per frame (>= 5)
//   PRESCALE_WIDTH : width of Prescale
// Ports
//   CLK         : system clock, rising edge
//   RST         : asynchronous reset, active low
//   P_DATA      : word to transmit
//   Data_Valid  : transmit request, honoured only in IDLE
//   Parity_En   : 1 = insert a parity bit
//   Parity_Type : 0 = even, 1 = odd
//   Stop_2      : 1 = two stop bits, 0 = one
//   Prescale    : bit period minus one, in clock cycles
//   TX_OUT      : registered serial line, idle high
//   Busy        : registered, high while a frame is in progress
//   Done        : registered, one-cycle pulse when a frame completes
module uart_tx_frame_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      Parity_En,
  input  logic                      Parity_Type,
  input  logic                      Stop_2,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy,
  output logic                      Done
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_en_r;
  logic                      par_bit_r;
  logic                      stop2_r;
  logic [PRESCALE_WIDTH-1:0] presc_r;
  logic [PRESCALE_WIDTH-1:0] period_cnt;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic                      stop_cnt;
  logic                      bit_end;

  assign bit_end = (period_cnt == presc_r);

  // TX_OUT is loaded with the value of the state being entered, so the line
  // changes on the same edge as the state and no output decoding is needed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      shreg      <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop2_r    <= 1'b0;
      presc_r    <= '0;
      period_cnt <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done       <= 1'b0;
      period_cnt <= bit_end ? '0 : period_cnt + 1'b1;
      case (state)
        IDLE: begin
          TX_OUT     <= 1'b1;
          Busy       <= 1'b0;
          period_cnt <= '0;
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          if (Data_Valid) begin
            shreg     <= P_DATA;
            par_en_r  <= Parity_En;
            par_bit_r <= (^P_DATA) ^ Parity_Type;
            stop2_r   <= Stop_2;
            presc_r   <= Prescale;
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            TX_OUT <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (par_en_r) begin
                state  <= PARITY;
                TX_OUT <= par_bit_r;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              TX_OUT  <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
        end
        STOP: begin
          TX_OUT <= 1'b1;
          if (bit_end) begin
            if (stop2_r && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              stop_cnt <= 1'b0;
              state    <= IDLE;
              Busy     <= 1'b0;
              Done     <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          TX_OUT     <= 1'b1;
          Busy       <= 1'b0;
          period_cnt <= '0;
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine
//   Directed bench for uart_tx_frame_engine. Two instances: an 8-bit/6-bit
//   prescale build and a 5-bit/3-bit prescale build. Each frame's expected line
//   sequence is a hand-written string, one character per transmitted bit.
module tb_uart_tx_frame_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] p_data8;
  logic [4:0] p_data5;
  logic       dv8, dv5;
  logic       pen, ptype, stop2;
  logic [5:0] presc8;
  logic [2:0] presc5;
  logic       tx8, busy8, done8;
  logic       tx5, busy5, done5;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          sel   = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_engine #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data8), .Data_Valid(dv8),
    .Parity_En(pen), .Parity_Type(ptype), .Stop_2(stop2), .Prescale(presc8),
    .TX_OUT(tx8), .Busy(busy8), .Done(done8)
  );

  uart_tx_frame_engine #(.DATA_WIDTH(5), .PRESCALE_WIDTH(3)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data5), .Data_Valid(dv5),
    .Parity_En(pen), .Parity_Type(ptype), .Stop_2(stop2), .Prescale(presc5),
    .TX_OUT(tx5), .Busy(busy5), .Done(done5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_tx, input logic e_busy, input logic e_done);
    logic tx, bz, dn;
    tx = (sel == 0) ? tx8   : tx5;
    bz = (sel == 0) ? busy8 : busy5;
    dn = (sel == 0) ? done8 : done5;
    check({tag, "_tx"},   {31'd0, tx}, {31'd0, e_tx});
    check({tag, "_busy"}, {31'd0, bz}, {31'd0, e_busy});
    check({tag, "_done"}, {31'd0, dn}, {31'd0, e_done});
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      check_outs($sformatf("%s_idle%0d", name, i), 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Called 1 ns after an edge; the request is sampled at the next edge (E0).
  // Checks every cycle of the frame, then the IDLE return at E0+N.
  task automatic run_frame(input int s, input logic [7:0] data, input logic pe,
                           input logic pt, input logic s2, input int p,
                           input string bits, input bit disturb,
                           input int rst_at, input string name);
    int nb;
    int n;
    logic e;
    nb    = bits.len();
    n     = nb * (p + 1);
    sel   = s;
    pen   = pe;
    ptype = pt;
    stop2 = s2;
    if (s == 0) begin
      p_data8 = data; presc8 = 6'(p); dv8 = 1'b1;
    end else begin
      p_data5 = data[4:0]; presc5 = 3'(p); dv5 = 1'b1;
    end
    @(posedge CLK); #1;
    dv8 = 1'b0;
    dv5 = 1'b0;
    for (int k = 0; k < n; k++) begin
      e = (bits[k / (p + 1)] == "1");
      check_outs($sformatf("%s_k%0d", name, k), e, 1'b1, 1'b0);
      if (k == rst_at) begin
        RST = 1'b0;
        #1;
        check_outs($sformatf("%s_rst_now", name), 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        check_outs($sformatf("%s_rst_hold", name), 1'b1, 1'b0, 1'b0);
        RST = 1'b1;
        return;
      end
      if (disturb) begin
        if (k == 3 * (p + 1)) begin
          p_data8 = ~data; pen = ~pe; presc8 = 6'd5; dv8 = 1'b1;
        end
        if (k == 3 * (p + 1) + 1) dv8 = 1'b0;
        if (k == n - 1)           dv8 = 1'b1;
      end
      @(posedge CLK); #1;
    end
    dv8 = 1'b0;
    dv5 = 1'b0;
    check_outs($sformatf("%s_end", name), 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    RST = 1'b0;
    p_data8 = 8'h00; p_data5 = 5'h00;
    dv8 = 1'b0; dv5 = 1'b0;
    pen = 1'b0; ptype = 1'b0; stop2 = 1'b0;
    presc8 = 6'd0; presc5 = 3'd0;

    #12;
    sel = 0; check_outs("reset8", 1'b1, 1'b0, 1'b0);
    sel = 1; check_outs("reset5", 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // 0xA5 LSB-first = 1,0,1,0,0,1,0,1
    run_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 0, "0101001011", 1'b0, -1, "a5_np");
    idle(1, "a5_np");
    run_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 0, "01010010101", 1'b0, -1, "a5_even");
    idle(1, "a5_even");
    run_frame(0, 8'hA5, 1'b1, 1'b1, 1'b0, 0, "01010010111", 1'b0, -1, "a5_odd");
    idle(1, "a5_odd");
    run_frame(0, 8'h01, 1'b1, 1'b0, 1'b0, 0, "01000000011", 1'b0, -1, "01_even");
    idle(1, "01_even");
    run_frame(0, 8'h01, 1'b1, 1'b1, 1'b0, 0, "01000000001", 1'b0, -1, "01_odd");
    idle(1, "01_odd");

    // 0x3C LSB-first = 0,0,1,1,1,1,0,0; even parity 0; two stop bits; 48 cycles
    run_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1, 3, "000111100011", 1'b0, -1, "3c_p3");
    idle(2, "3c_p3");

    // Inputs disturbed mid-frame, request held into the last STOP cycle,
    // then a request in the Done cycle starts the next frame back-to-back.
    run_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1, "0101001011", 1'b1, -1, "iso");
    run_frame(0, 8'h01, 1'b1, 1'b0, 1'b0, 0, "01000000011", 1'b0, -1, "b2b");
    idle(1, "b2b");

    // Reset during data bit 3 (frame bit 4) with 3 cycles per bit
    run_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 2, "01010010101", 1'b0, 13, "rst");
    run_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 0, "0101001011", 1'b0, -1, "post_rst");
    idle(1, "post_rst");

    // 5-bit build: 0x1F odd parity -> parity 0; max prescale 7; 64 cycles
    sel = 1;
    idle(1, "w5_pre");
    run_frame(1, 8'h1F, 1'b1, 1'b1, 1'b0, 7, "01111101", 1'b0, -1, "w5");
    idle(1, "w5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
